mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified memory between instruction fetch (IF, read-only)
//   and the data-memory stage (MEM, read/write) of the 5-stage pipeline.
//   Issues one access at a time, waits on the memory's done handshake, and returns data.
//   Drives per-requester stalls into the hazard/stall logic.
//   Discards wrong-path fetches on branch/jump flush and flags hung memory via a watchdog.
// PARAMETERS
//   ADDR_W   16   address width
//   DATA_W   16   data width
//   TIMEOUT  64   max cycles in a WAIT state before watchdog abort (>=2)
// PORTS
//   clk        in   1       clock; all state on rising edge
//   rst        in   1       asynchronous, active-high reset
//   if_req     in   1       fetch request; held until if_valid
//   if_addr    in   ADDR_W  fetch PC
//   if_flush   in   1       kill current/pending fetch (taken branch/jump)
//   dm_req     in   1       data request; held until dm_valid
//   dm_wr      in   1       1=write, 0=read
//   dm_addr    in   ADDR_W  data address
//   dm_wdata   in   DATA_W  write data
//   mem_rdata  in   DATA_W  memory read data, valid with mem_done
//   mem_done   in   1       one-cycle completion pulse from memory
//   mem_req    out  1       one-cycle access start strobe
//   mem_wr     out  1       access is write
//   mem_addr   out  ADDR_W  access address
//   mem_wdata  out  DATA_W  access write data
//   if_rdata   out  DATA_W  fetched instruction
//   if_valid   out  1       one-cycle fetch completion
//   if_stall   out  1       if_req & ~if_valid (combinational)
//   dm_rdata   out  DATA_W  load data
//   dm_valid   out  1       one-cycle data completion
//   dm_stall   out  1       dm_req & ~dm_valid (combinational)
//   mem_err    out  1       sticky watchdog error
// BEHAVIOUR
//   - Reset: state IDLE. All registered outputs are 0: mem_*, if_*, dm_*, mem_err. Watchdog counter 0, kill flag 0.
//     Asserting rst mid-access abandons it at once; mem_req drops asynchronously.
//   - States: IDLE, D_WAIT, F_WAIT, D_DONE, F_DONE.
//   - IDLE:
//     - dm_req=1: latch dm_wr/dm_addr/dm_wdata into mem_*; go to D_WAIT.
//     - Otherwise, if_req=1 and if_flush=0: latch if_addr, mem_wr=0; go to F_WAIT.
//     - Otherwise stay. Data always wins over fetch, because MEM holds the older instruction.
//   - mem_req is 1 only in the first cycle of D_WAIT/F_WAIT.
//     mem_wr/addr/wdata are held stable for the whole WAIT state.
//   - WAIT states honour mem_done in any cycle, including the mem_req cycle.
//     The watchdog increments each WAIT cycle and clears when leaving WAIT.
//   - D_WAIT & mem_done: dm_rdata<=mem_rdata (written but ignored for writes); go to D_DONE.
//   - F_WAIT & mem_done: if the kill flag is clear, if_rdata<=mem_rdata and go to F_DONE.
//     If the kill flag is set, go straight to IDLE with no if_valid.
//   - if_flush in F_WAIT sets the kill flag; the flag clears on leaving F_WAIT.
//     if_flush in IDLE suppresses a fetch start that cycle.
//   - D_DONE: dm_valid=1 for exactly this cycle, then IDLE.
//     F_DONE: if_valid=1 for exactly this cycle, then IDLE.
//     No new access starts from a DONE state, so a still-held stale req is never reissued.
//   - Watchdog: WAIT count reaching TIMEOUT with no mem_done sets mem_err (sticky until rst).
//     The access completes as if done with rdata=0: D_DONE, or F_DONE unless killed.
//   - Throughput: minimum 3 cycles per access (issue, done, DONE).
//     Back-to-back data requests are served before a pending fetch.
//   - dm_req arriving during F_WAIT waits; it is issued in the first IDLE cycle after F_DONE.
// TESTING
//   1. Reset, then if_req=1, if_addr=0x0010, mem_done 2 cycles after mem_req,
//      mem_rdata=0xA5A5 -> mem_req 1 cycle, mem_addr=0x0010, if_valid 1 cycle
//      with if_rdata=0xA5A5, if_stall low only that cycle.
//   2. if_req and dm_req (wr=1, addr=0x0200, wdata=0x1234) both rise in IDLE ->
//      data issued first (mem_wr=1, 0x0200/0x1234); dm_valid; then fetch issued;
//      if_stall high throughout data access.
//   3. Fetch in F_WAIT, pulse if_flush, mem_done with 0xDEAD -> no if_valid,
//      if_rdata unchanged, state back to IDLE, next fetch issued normally.
//   4. Data read, mem_done never asserted -> after 64 WAIT cycles mem_err=1,
//      dm_valid with dm_rdata=0x0000; mem_err stays 1 across further accesses until rst.
//   5. Assert rst during D_WAIT -> mem_req, dm_valid, mem_err all 0 immediately
//      (before the next clk edge); after release a new dm_req issues cleanly.
//   6. dm_req held constant through D_DONE -> exactly one mem_req per access; no reissue.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares a single-port memory between instruction fetch and the
//            data stage; data has priority, with flush-kill and a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    output logic              mem_err
);

    localparam int c_WDOG_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_D_WAIT = 3'd1;
    localparam logic [2:0] c_S_F_WAIT = 3'd2;
    localparam logic [2:0] c_S_D_DONE = 3'd3;
    localparam logic [2:0] c_S_F_DONE = 3'd4;

    logic [2:0]          r_state, w_state;
    logic                r_mem_req, w_mem_req;
    logic                r_mem_wr, w_mem_wr;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata;
    logic                r_if_valid, w_if_valid;
    logic [DATA_W-1:0]   r_dm_rdata, w_dm_rdata;
    logic                r_dm_valid, w_dm_valid;
    logic                r_mem_err, w_mem_err;
    logic [c_WDOG_W-1:0] r_wdog, w_wdog;
    logic                r_kill, w_kill;
    logic                w_expire;
    logic                w_kill_now;

    assign w_expire   = (r_wdog == c_WDOG_W'(TIMEOUT - 1));
    // A flush in the completing cycle still marks the fetch as wrong-path.
    assign w_kill_now = r_kill | if_flush;

    always_comb begin
        w_state     = r_state;
        w_mem_req   = 1'b0;
        w_mem_wr    = r_mem_wr;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        w_if_rdata  = r_if_rdata;
        w_if_valid  = 1'b0;
        w_dm_rdata  = r_dm_rdata;
        w_dm_valid  = 1'b0;
        w_mem_err   = r_mem_err;
        w_wdog      = '0;
        w_kill      = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (dm_req) begin
                    w_mem_req   = 1'b1;
                    w_mem_wr    = dm_wr;
                    w_mem_addr  = dm_addr;
                    w_mem_wdata = dm_wdata;
                    w_state     = c_S_D_WAIT;
                end else if (if_req && !if_flush) begin
                    w_mem_req  = 1'b1;
                    w_mem_wr   = 1'b0;
                    w_mem_addr = if_addr;
                    w_state    = c_S_F_WAIT;
                end
            end
            c_S_D_WAIT: begin
                if (mem_done || w_expire) begin
                    w_dm_rdata = mem_done ? mem_rdata : '0;
                    w_mem_err  = r_mem_err | ~mem_done;
                    w_dm_valid = 1'b1;
                    w_state    = c_S_D_DONE;
                end else begin
                    w_wdog = r_wdog + 1'b1;
                end
            end
            c_S_F_WAIT: begin
                if (mem_done || w_expire) begin
                    w_mem_err = r_mem_err | ~mem_done;
                    if (w_kill_now) begin
                        w_state = c_S_IDLE;
                    end else begin
                        w_if_rdata = mem_done ? mem_rdata : '0;
                        w_if_valid = 1'b1;
                        w_state    = c_S_F_DONE;
                    end
                end else begin
                    w_wdog = r_wdog + 1'b1;
                    w_kill = w_kill_now;
                end
            end
            // DONE states never issue, so a still-held request is not replayed.
            c_S_D_DONE: w_state = c_S_IDLE;
            c_S_F_DONE: w_state = c_S_IDLE;
            default:    w_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_valid  <= 1'b0;
            r_mem_err   <= 1'b0;
            r_wdog      <= '0;
            r_kill      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_mem_req   <= w_mem_req;
            r_mem_wr    <= w_mem_wr;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_if_rdata  <= w_if_rdata;
            r_if_valid  <= w_if_valid;
            r_dm_rdata  <= w_dm_rdata;
            r_dm_valid  <= w_dm_valid;
            r_mem_err   <= w_mem_err;
            r_wdog      <= w_wdog;
            r_kill      <= w_kill;
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign mem_err   = r_mem_err;
    assign if_stall  = if_req & ~r_if_valid;
    assign dm_stall  = dm_req & ~r_dm_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, dm_req, dm_wr, mem_done;
    logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        mem_req, mem_wr, if_valid, if_stall, dm_valid, dm_stall, mem_err;
    logic [15:0] mem_addr, mem_wdata, if_rdata, dm_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int req_cnt  = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_req) req_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_flush = 0; dm_req = 0; dm_wr = 0; mem_done = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        step(); step();
        check("rst_mem_req", mem_req, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        rst = 1'b0;
        step();

        // Plain fetch, done two cycles after the strobe
        if_req = 1; if_addr = 16'h0010; #1;
        check("t1_stall_idle", if_stall, 1);
        step();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 16'h0010);
        check("t1_mem_wr", mem_wr, 0);
        step();
        check("t1_req_one_cycle", mem_req, 0);
        check("t1_stall_wait", if_stall, 1);
        step();
        mem_done = 1; mem_rdata = 16'hA5A5;
        step();
        mem_done = 0;
        check("t1_if_valid", if_valid, 1);
        check("t1_if_rdata", if_rdata, 16'hA5A5);
        check("t1_stall_low", if_stall, 0);
        if_req = 0;
        step();
        check("t1_valid_one_cycle", if_valid, 0);

        // Simultaneous fetch and write: data first
        if_req = 1; if_addr = 16'h0020;
        dm_req = 1; dm_wr = 1; dm_addr = 16'h0200; dm_wdata = 16'h1234;
        step();
        check("t2_d_req", mem_req, 1);
        check("t2_d_wr", mem_wr, 1);
        check("t2_d_addr", mem_addr, 16'h0200);
        check("t2_d_wdata", mem_wdata, 16'h1234);
        check("t2_if_stall_dwait", if_stall, 1);
        mem_done = 1; mem_rdata = 16'h5555;
        step();
        mem_done = 0;
        check("t2_dm_valid", dm_valid, 1);
        check("t2_if_stall_ddone", if_stall, 1);
        check("t2_no_req_ddone", mem_req, 0);
        dm_req = 0;
        step();
        check("t2_idle_no_req", mem_req, 0);
        step();
        check("t2_f_req", mem_req, 1);
        check("t2_f_addr", mem_addr, 16'h0020);
        check("t2_f_wr", mem_wr, 0);
        mem_done = 1; mem_rdata = 16'h1111;
        step();
        mem_done = 0;
        check("t2_if_valid", if_valid, 1);
        check("t2_if_rdata", if_rdata, 16'h1111);
        if_req = 0;
        step();

        // Flushed fetch is dropped, next fetch proceeds
        if_req = 1; if_addr = 16'h0030;
        step();
        check("t3_req", mem_req, 1);
        check("t3_addr", mem_addr, 16'h0030);
        if_flush = 1;
        step();
        if_flush = 0; if_addr = 16'h0040;
        mem_done = 1; mem_rdata = 16'hDEAD;
        step();
        mem_done = 0;
        check("t3_no_if_valid", if_valid, 0);
        check("t3_if_rdata_kept", if_rdata, 16'h1111);
        check("t3_no_req", mem_req, 0);
        step();
        check("t3_next_req", mem_req, 1);
        check("t3_next_addr", mem_addr, 16'h0040);
        mem_done = 1; mem_rdata = 16'h4444;
        step();
        mem_done = 0;
        check("t3_next_valid", if_valid, 1);
        check("t3_next_rdata", if_rdata, 16'h4444);
        if_req = 0;
        step();

        // Watchdog on a hung read
        check("t4_dm_rdata_before", dm_rdata, 16'h5555);
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0300; mem_rdata = 16'h7777;
        step();
        check("t4_req", mem_req, 1);
        for (int i = 0; i < 63; i++) step();
        check("t4_no_err_yet", mem_err, 0);
        check("t4_no_valid_yet", dm_valid, 0);
        step();
        check("t4_err", mem_err, 1);
        check("t4_dm_valid", dm_valid, 1);
        check("t4_dm_rdata_zero", dm_rdata, 16'h0000);
        dm_req = 0;
        step();
        dm_req = 1; dm_wr = 1; dm_addr = 16'h0310;
        step();
        check("t4_next_req", mem_req, 1);
        mem_done = 1;
        step();
        mem_done = 0;
        check("t4_next_valid", dm_valid, 1);
        check("t4_err_sticky", mem_err, 1);
        dm_req = 0;
        step();

        // Reset mid-access acts immediately
        dm_req = 1; dm_wr = 0; dm_addr = 16'h0320;
        step();
        check("t5_req", mem_req, 1);
        rst = 1; #1;
        check("t5_async_mem_req", mem_req, 0);
        check("t5_async_dm_valid", dm_valid, 0);
        check("t5_async_mem_err", mem_err, 0);
        dm_req = 0;
        step();
        rst = 0;
        step();

        // Held request through DONE: single strobe only
        req_cnt = 0;
        dm_req = 1; dm_wr = 1; dm_addr = 16'h0330; dm_wdata = 16'hBEEF;
        step();
        check("t6_req", mem_req, 1);
        check("t6_addr", mem_addr, 16'h0330);
        mem_done = 1;
        step();
        mem_done = 0;
        check("t6_valid", dm_valid, 1);
        check("t6_dm_stall", dm_stall, 0);
        step();
        check("t6_no_reissue", mem_req, 0);
        check("t6_valid_one_cycle", dm_valid, 0);
        dm_req = 0;
        step(); step();
        check("t6_req_count", req_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
